sram_fifo_ctrl: RTL and testbench
=================================

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 128, SHALL set the word width.
REQ-002 Parameter ADDR_WIDTH, default 10, SHALL set the SRAM address width.
REQ-003 Parameter DEPTH, default 1024, SHALL set SRAM capacity in words (DEPTH <= 2**ADDR_WIDTH).
REQ-004 clk  in  1  SHALL be the single clock; all state on rising edge.
REQ-005 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-006 in_valid  in  1  SHALL indicate a push word on in_data.
REQ-007 in_data  in  DATA_WIDTH  SHALL carry the push word.
REQ-008 in_ready  out  1  SHALL indicate a push is accepted this cycle.
REQ-009 out_valid  out  1  SHALL indicate out_data holds the head word.
REQ-010 out_data  out  DATA_WIDTH  SHALL carry the head word.
REQ-011 out_ready  in  1  SHALL indicate the consumer takes out_data this cycle.
REQ-012 count  out  ADDR_WIDTH+1  SHALL report total words held (SRAM + in-flight read + output register).
REQ-013 sram_wen, sram_wadr[ADDR_WIDTH], sram_wdata[DATA_WIDTH]  out  SHALL drive the SRAM write port.
REQ-014 sram_ren, sram_radr[ADDR_WIDTH]  out; sram_rdata[DATA_WIDTH]  in  SHALL connect the SRAM read port (rdata valid one cycle after ren sampled).

Function
REQ-015 Push SHALL occur when in_valid && in_ready; same cycle sram_wen=1, sram_wadr=wr_ptr, sram_wdata=in_data (combinational).
REQ-016 in_ready SHALL equal (sram_cnt != DEPTH); sram_cnt counts words resident in SRAM only.
REQ-017 wr_ptr and rd_ptr SHALL increment by one per write/read issue and wrap DEPTH-1 -> 0.
REQ-018 Read FSM states SHALL be RD_IDLE, RD_WAIT, RD_HOLD; out_valid=1 only in RD_HOLD.
REQ-019 RD_IDLE: if sram_cnt>0 assert sram_ren, sram_radr=rd_ptr, go RD_WAIT; else stay.
REQ-020 RD_WAIT: capture sram_rdata into out_data, go RD_HOLD (unconditional).
REQ-021 RD_HOLD: if out_ready and sram_cnt>0, issue read and go RD_WAIT; if out_ready and sram_cnt==0, go RD_IDLE; else hold out_data stable.
REQ-022 Read issue decision SHALL use registered sram_cnt; a word pushed in cycle t SHALL be readable no earlier than cycle t+1 (no write-through).
REQ-023 sram_cnt SHALL update +1 on push, -1 on read issue, unchanged when both coincide.
REQ-024 count SHALL equal sram_cnt + (state==RD_WAIT) + (state==RD_HOLD), max DEPTH+1.
REQ-025 Read and write SHALL never target the same address in one cycle (guaranteed by REQ-016/019).
REQ-026 Sustained throughput SHALL be one word per two cycles; first-word latency from push to out_valid SHALL be 3 cycles.
REQ-027 sram_wen/sram_ren SHALL be 0 in any cycle without a push/read issue.

Reset
REQ-028 On rst: wr_ptr=0, rd_ptr=0, sram_cnt=0, state=RD_IDLE, out_valid=0, out_data=0, count=0, in_ready=1, sram_ren=0; sram_wen=0 while rst asserted.
REQ-029 Reset mid-operation SHALL discard all stored and in-flight data; SRAM contents are not cleared.

Structure
REQ-030 Read-FSM state enum and default width constants SHALL live in shared package enclave_pkg.
REQ-031 Block SHALL be a single module with no sub-modules; the sram instance lives in the parent.

Verification
REQ-032 Bench SHALL instance sram_fifo_ctrl with the team's sram model (DEPTH=1024, DATA_WIDTH=128).
REQ-033 Push 137 once, out_ready=1 -> out_valid rises 3 cycles later with out_data=137; count 1 -> 0 after pop.
REQ-034 Push 137, 84, 39 back-to-back, out_ready=0 -> count=3, out_data=137 held; then out_ready=1 -> pops 137, 84, 39 in order.
REQ-035 Push 1025 words with out_ready=0 -> in_ready=0 at count=1025 (1024 in SRAM + 1 in output), 1026th push refused; drain returns all in order.
REQ-036 Push/pop 2048 words continuously -> both pointers wrap twice, data matches sequence, sram_wen and sram_ren never share an address.
REQ-037 Assert rst while state=RD_WAIT with count=5 -> next cycle count=0, out_valid=0, in_ready=1; subsequent push 84 pops as 84.

Source files
------------

// File: rtl/enclave_pkg.sv
// Shared types and default sizing for the enclave storage blocks.
package enclave_pkg;

   localparam int DEF_DATA_WIDTH = 128;
   localparam int DEF_ADDR_WIDTH = 10;
   localparam int DEF_DEPTH      = 1024;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_WAIT = 2'd1,
      RD_HOLD = 2'd2
   } rd_state_e;

endpackage

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over an external single-cycle-latency SRAM, with a one-word
// output register fed by a three-state read FSM.
module sram_fifo_ctrl
   import enclave_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  sram_wen,
   output logic [ADDR_WIDTH-1:0] sram_wadr,
   output logic [DATA_WIDTH-1:0] sram_wdata,
   output logic                  sram_ren,
   output logic [ADDR_WIDTH-1:0] sram_radr,
   input  logic [DATA_WIDTH-1:0] sram_rdata
);

   localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] ADR_LAST = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ADR_ONE  = ADDR_WIDTH'(1);

   rd_state_e             state_q, state_d;
   logic [ADDR_WIDTH:0]   sram_cnt_q, sram_cnt_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  push;
   logic                  rd_issue;
   logic                  cnt_nz;

   function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == ADR_LAST) ? '0 : p + ADR_ONE;
   endfunction

   assign cnt_nz   = (sram_cnt_q != '0);
   assign in_ready = (sram_cnt_q != CNT_FULL);
   // Gated by rst so no write escapes while the controller is being cleared.
   assign push     = in_valid && in_ready && !rst;

   assign sram_wen   = push;
   assign sram_wadr  = wr_ptr_q;
   assign sram_wdata = in_data;
   assign sram_ren   = rd_issue;
   assign sram_radr  = rd_ptr_q;

   assign out_valid = (state_q == RD_HOLD);
   assign out_data  = out_data_q;
   assign count     = sram_cnt_q + (ADDR_WIDTH+1)'(state_q != RD_IDLE);

   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      rd_issue   = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (cnt_nz) begin
               rd_issue = 1'b1;
               state_d  = RD_WAIT;
            end
         end
         RD_WAIT: begin
            out_data_d = sram_rdata;
            state_d    = RD_HOLD;
         end
         RD_HOLD: begin
            if (out_ready) begin
               if (cnt_nz) begin
                  rd_issue = 1'b1;
                  state_d  = RD_WAIT;
               end else begin
                  state_d = RD_IDLE;
               end
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = rd_issue ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      sram_cnt_d = sram_cnt_q;
      case ({push, rd_issue})
         2'b10:   sram_cnt_d = sram_cnt_q + CNT_ONE;
         2'b01:   sram_cnt_d = sram_cnt_q - CNT_ONE;
         default: sram_cnt_d = sram_cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RD_IDLE;
         sram_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         sram_cnt_q <= sram_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         out_data_q <= out_data_d;
      end
   end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl with a behavioural SRAM and a
// queue-based reference model of the FIFO contents.
module tb_sram_fifo_ctrl;

   localparam int DW    = 128;
   localparam int AW    = 10;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready = 1'b0;
   logic [AW:0]   count;
   logic          sram_wen;
   logic [AW-1:0] sram_wadr;
   logic [DW-1:0] sram_wdata;
   logic          sram_ren;
   logic [AW-1:0] sram_radr;
   logic [DW-1:0] sram_rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .count(count),
      .sram_wen(sram_wen), .sram_wadr(sram_wadr), .sram_wdata(sram_wdata),
      .sram_ren(sram_ren), .sram_radr(sram_radr), .sram_rdata(sram_rdata)
   );

   // Behavioural SRAM: write on the edge, read data registered one cycle after ren.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (sram_wen) mem[sram_wadr] <= sram_wdata;
      if (sram_ren) sram_rdata <= mem[sram_radr];
   end

   // Reference model: every word held, in order, plus where the head word sits.
   logic [DW-1:0] mq[$];
   bit            head_fetched;   // head word has been read out of the SRAM
   bit            head_arriving;  // head word still one cycle from the output
   int            wr_n, rd_n;

   task automatic model_clear();
      mq.delete();
      head_fetched  = 0;
      head_arriving = 0;
      wr_n = 0;
      rd_n = 0;
   endtask

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy, output bit acc);
      int  in_sram;
      bit  e_ir, e_ov, e_ren, e_push;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      @(negedge clk);
      in_sram = mq.size() - (head_fetched ? 1 : 0);
      e_ir    = (in_sram != DEPTH);
      e_ov    = head_fetched && !head_arriving;
      e_ren   = (in_sram > 0) && (!head_fetched || (e_ov && ordy));
      e_push  = iv && e_ir;
      chk("in_ready", DW'(in_ready), DW'(e_ir));
      chk("out_valid", DW'(out_valid), DW'(e_ov));
      chk("count", DW'(count), DW'(mq.size()));
      chk("sram_wen", DW'(sram_wen), DW'(e_push));
      chk("sram_ren", DW'(sram_ren), DW'(e_ren));
      if (e_ov) chk("out_data", out_data, mq[0]);
      if (e_push) chk("sram_wadr", DW'(sram_wadr), DW'(wr_n % DEPTH));
      if (e_ren) chk("sram_radr", DW'(sram_radr), DW'(rd_n % DEPTH));
      if (sram_wen && sram_ren) chk("addr_clash", DW'(sram_wadr != sram_radr), DW'(1));
      @(posedge clk);
      if (head_arriving) begin
         head_arriving = 0;
      end else begin
         if (e_ov && ordy) begin
            void'(mq.pop_front());
            head_fetched = 0;
         end
         if (e_ren) begin
            head_fetched  = 1;
            head_arriving = 1;
            rd_n++;
         end
      end
      if (e_push) begin
         mq.push_back(d);
         wr_n++;
      end
      acc = e_push;
      #1;
   endtask

   task automatic drain(input string name);
      bit acc;
      int n = 0;
      while (mq.size() > 0 && n < 5000) begin
         step(1'b0, '0, 1'b1, acc);
         n++;
      end
      chk({name, "_drain_done"}, DW'(mq.size()), DW'(0));
   endtask

   task automatic do_reset();
      in_valid  = 1'b1;
      in_data   = 128'hDEAD;
      out_ready = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      chk("rst_count", DW'(count), DW'(0));
      chk("rst_out_valid", DW'(out_valid), DW'(0));
      chk("rst_in_ready", DW'(in_ready), DW'(1));
      chk("rst_sram_wen", DW'(sram_wen), DW'(0));
      chk("rst_sram_ren", DW'(sram_ren), DW'(0));
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      model_clear();
   endtask

   typedef struct {
      logic          iv;
      logic [DW-1:0] d;
      logic          ordy;
      logic          e_ov;
      logic [DW-1:0] e_od;
      int            e_cnt;
      logic          e_ir;
   } vec_t;

   vec_t tbl[15];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected test end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit acc;
      int pushed;
      int cyc;

      // Single push with free consumer, then three back-to-back pushes held.
      tbl[0]  = '{1'b1, 128'd137, 1'b1, 1'b0, 128'd0,   0, 1'b1};
      tbl[1]  = '{1'b0, 128'd0,   1'b1, 1'b0, 128'd0,   1, 1'b1};
      tbl[2]  = '{1'b0, 128'd0,   1'b1, 1'b0, 128'd0,   1, 1'b1};
      tbl[3]  = '{1'b0, 128'd0,   1'b1, 1'b1, 128'd137, 1, 1'b1};
      tbl[4]  = '{1'b0, 128'd0,   1'b1, 1'b0, 128'd0,   0, 1'b1};
      tbl[5]  = '{1'b1, 128'd137, 1'b0, 1'b0, 128'd0,   0, 1'b1};
      tbl[6]  = '{1'b1, 128'd84,  1'b0, 1'b0, 128'd0,   1, 1'b1};
      tbl[7]  = '{1'b1, 128'd39,  1'b0, 1'b0, 128'd0,   2, 1'b1};
      tbl[8]  = '{1'b0, 128'd0,   1'b0, 1'b1, 128'd137, 3, 1'b1};
      tbl[9]  = '{1'b0, 128'd0,   1'b1, 1'b1, 128'd137, 3, 1'b1};
      tbl[10] = '{1'b0, 128'd0,   1'b1, 1'b0, 128'd0,   2, 1'b1};
      tbl[11] = '{1'b0, 128'd0,   1'b1, 1'b1, 128'd84,  2, 1'b1};
      tbl[12] = '{1'b0, 128'd0,   1'b1, 1'b0, 128'd0,   1, 1'b1};
      tbl[13] = '{1'b0, 128'd0,   1'b1, 1'b1, 128'd39,  1, 1'b1};
      tbl[14] = '{1'b0, 128'd0,   1'b1, 1'b0, 128'd0,   0, 1'b1};

      model_clear();
      do_reset();

      for (int i = 0; i < 15; i++) begin
         in_valid  = tbl[i].iv;
         in_data   = tbl[i].d;
         out_ready = tbl[i].ordy;
         @(negedge clk);
         chk($sformatf("tbl%0d_out_valid", i), DW'(out_valid), DW'(tbl[i].e_ov));
         chk($sformatf("tbl%0d_count", i), DW'(count), DW'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d_in_ready", i), DW'(in_ready), DW'(tbl[i].e_ir));
         if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_od);
         @(posedge clk);
         #1;
      end

      // Fill to capacity with the consumer stalled, then drain.
      do_reset();
      for (int i = 0; i < 1030; i++) step(1'b1, DW'(i + 1000), 1'b0, acc);
      chk("full_count", DW'(count), DW'(DEPTH + 1));
      chk("full_in_ready", DW'(in_ready), DW'(0));
      step(1'b1, 128'hBAD, 1'b0, acc);
      chk("full_refused_count", DW'(count), DW'(DEPTH + 1));
      drain("full");

      // Continuous push/pop of 2048 words; both pointers wrap twice.
      do_reset();
      pushed = 0;
      cyc    = 0;
      while (pushed < 2048 && cyc < 10000) begin
         step(1'b1, DW'(pushed + 5000), 1'b1, acc);
         if (acc) pushed++;
         cyc++;
      end
      chk("stream_pushed", DW'(pushed), DW'(2048));
      drain("stream");

      // Randomized traffic, with bursts of consumer stall.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic ordy;
         ordy = ((i / 500) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
         step($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom, $urandom}, ordy, acc);
      end
      drain("random");

      // Reset while a read is in flight with five words held.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, DW'(100 + i), 1'b0, acc);
      step(1'b1, DW'(105), 1'b1, acc);
      chk("pre_rst_count", DW'(count), DW'(5));
      chk("pre_rst_out_valid", DW'(out_valid), DW'(0));
      do_reset();
      step(1'b1, DW'(84), 1'b0, acc);
      step(1'b0, '0, 1'b0, acc);
      step(1'b0, '0, 1'b0, acc);
      chk("post_rst_out_data", out_data, DW'(84));
      chk("post_rst_count", DW'(count), DW'(1));
      drain("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
